// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - word-addressed register bus between software bridge and irq_ctrl
// Ports:
//   addr  : byte offset into the block (only [3:2] decoded by the slave)
//   we    : single-cycle write strobe
//   wdata : write data
//   rdata : combinational read data from the slave
interface irq_ctrl_if;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - external interrupt controller: sync, edge/level pending, mask, HWInt to CP0
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   src     : raw device interrupt lines (asynchronous, active high)
//   bus     : register bus slave (MASK=0x0, MODE=0x4, PEND=0x8, TOP=0xC)
//   HWInt   : registered pending-and-enabled vector to CP0
//   any_irq : registered OR of HWInt
module irq_ctrl #(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    src,
    irq_ctrl_if.slave     bus,
    output logic [5:0]    HWInt,
    output logic          any_irq
);

    // Bits at or above NSRC do not exist: they read 0 and ignore writes.
    localparam logic [5:0] VALID = 6'((7'd1 << NSRC) - 7'd1);

    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] prev;
    logic [5:0] mask;
    logic [5:0] mode;
    logic [5:0] pend;

    logic [5:0] sync;
    logic [5:0] rise;
    logic       wr_mask;
    logic       wr_mode;
    logic       wr_pend;
    logic [5:0] mode_chg;
    logic [5:0] w1c;
    logic [5:0] pend_next;
    logic [5:0] active;
    logic [2:0] top_idx;
    logic       top_valid;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign rise    = sync & ~prev;

    assign wr_mask = bus.we && (bus.addr[3:2] == 2'd0);
    assign wr_mode = bus.we && (bus.addr[3:2] == 2'd1);
    assign wr_pend = bus.we && (bus.addr[3:2] == 2'd2);

    // A mode switch discards whatever was pending on that bit; the new mode
    // only starts to govern the bit from the following cycle.
    assign mode_chg = wr_mode ? ((bus.wdata[5:0] ^ mode) & VALID) : 6'd0;

    // W1C only touches edge-mode bits; level bits track the line anyway.
    assign w1c = wr_pend ? (bus.wdata[5:0] & mode) : 6'd0;

    // Edge bits: a new rising edge beats a simultaneous W1C.
    assign pend_next = ((~mode & sync) | (mode & (rise | (pend & ~w1c))))
                       & ~mode_chg & VALID;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= 6'd0;
            end
            prev <= 6'd0;
        end else begin
            sync_q[0] <= src & VALID;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev <= sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask    <= 6'd0;
            mode    <= 6'd0;
            pend    <= 6'd0;
            HWInt   <= 6'd0;
            any_irq <= 1'b0;
        end else begin
            if (wr_mask) begin
                mask <= bus.wdata[5:0] & VALID;
            end
            if (wr_mode) begin
                mode <= bus.wdata[5:0] & VALID;
            end
            pend    <= pend_next;
            HWInt   <= pend & mask;
            any_irq <= |(pend & mask);
        end
    end

    assign active    = pend & mask;
    assign top_valid = |active;

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        top_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr[3:2])
            2'd0: bus.rdata = {26'd0, mask};
            2'd1: bus.rdata = {26'd0, mode};
            2'd2: bus.rdata = {26'd0, pend};
            2'd3: bus.rdata = {top_valid, 28'd0, top_idx};
            default: bus.rdata = 32'd0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:6]};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - randomized and directed bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;

    localparam int S = 2;

    logic       clk;
    logic       reset;
    logic [5:0] src;
    logic [5:0] HWInt;
    logic       any_irq;

    irq_ctrl_if bus_if ();

    irq_ctrl #(.NSRC(6), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .bus     (bus_if.slave),
        .HWInt   (HWInt),
        .any_irq (any_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: registers as software sees them, plus the sampled src history
    // (newest first) that the synchroniser delays.
    logic [5:0] m_mask, m_mode, m_pend, m_hw;
    logic [5:0] hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = 6'd0;
        m_mode = 6'd0;
        m_pend = 6'd0;
        m_hw   = 6'd0;
        hist.delete();
        for (int k = 0; k <= S; k++) hist.push_back(6'd0);
    endtask

    function automatic logic [31:0] exp_rdata(input logic [3:0] a);
        logic [5:0] act;
        act = m_pend & m_mask;
        case (a[3:2])
            2'd0: return {26'd0, m_mask};
            2'd1: return {26'd0, m_mode};
            2'd2: return {26'd0, m_pend};
            default: begin
                for (int i = 0; i < 6; i++)
                    if (act[i]) return {1'b1, 28'd0, 3'(i)};
                return 32'd0;
            end
        endcase
    endfunction

    // One rising edge as the spec describes it, using inputs present at the edge.
    task automatic model_edge();
        logic [5:0] sy, pv, np;
        logic [1:0] reg_sel;
        sy = hist[S-1];
        pv = hist[S];
        reg_sel = bus_if.addr[3:2];
        for (int i = 0; i < 6; i++) begin
            if (bus_if.we && reg_sel == 2'd1 && bus_if.wdata[i] != m_mode[i])
                np[i] = 1'b0;
            else if (!m_mode[i])
                np[i] = sy[i];
            else if (sy[i] && !pv[i])
                np[i] = 1'b1;
            else if (bus_if.we && reg_sel == 2'd2 && bus_if.wdata[i])
                np[i] = 1'b0;
            else
                np[i] = m_pend[i];
        end
        m_hw = m_pend & m_mask;
        if (bus_if.we && reg_sel == 2'd0) m_mask = bus_if.wdata[5:0];
        if (bus_if.we && reg_sel == 2'd1) m_mode = bus_if.wdata[5:0];
        m_pend = np;
        hist.push_front(src);
        void'(hist.pop_back());
    endtask

    // Inputs are already set; check the read path before the edge (old values
    // even for a same-cycle write), step the edge, check outputs at negedge.
    task automatic tick();
        #1;
        chk("rdata", bus_if.rdata, exp_rdata(bus_if.addr));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("HWInt", {26'd0, HWInt}, {26'd0, m_hw});
        chk("any_irq", {31'd0, any_irq}, {31'd0, |m_hw});
    endtask

    task automatic idle(input int n);
        bus_if.we = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.we    = 1'b1;
        tick();
        bus_if.we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        bus_if.addr = a;
        bus_if.we   = 1'b0;
        #1;
        chk(tag, bus_if.rdata, exp);
    endtask

    // Reset asserted away from the clock edge; outputs must drop before the next edge.
    task automatic async_reset();
        @(posedge clk);
        model_edge();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_hwint", {26'd0, HWInt}, 32'd0);
        chk("rst_any", {31'd0, any_irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        src          = 6'd0;
        bus_if.addr  = 4'd0;
        bus_if.we    = 1'b0;
        bus_if.wdata = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state of all registers and outputs.
        for (int a = 0; a < 16; a += 4) rd_chk("reset_rd", 4'(a), 32'd0);
        chk("reset_hw", {26'd0, HWInt}, 32'd0);
        chk("reset_any", {31'd0, any_irq}, 32'd0);

        // Level mode latency: HWInt rises on the 4th edge after src rises.
        wr(4'h0, 32'h3F);
        wr(4'h4, 32'h00);
        src = 6'h04;
        bus_if.addr = 4'hC;
        idle(3);
        chk("lvl_early", {26'd0, HWInt}, 32'd0);
        idle(1);
        chk("lvl_hw", {26'd0, HWInt}, 32'h04);
        rd_chk("lvl_top", 4'hC, 32'h8000_0002);
        src = 6'h00;
        idle(4);
        chk("lvl_drop", {26'd0, HWInt}, 32'd0);

        // Edge mode: a one-cycle pulse latches and stays.
        wr(4'h4, 32'h01);
        wr(4'h0, 32'h01);
        src = 6'h01;
        idle(1);
        src = 6'h00;
        idle(6);
        chk("edge_hw", {26'd0, HWInt}, 32'h01);
        rd_chk("edge_pend", 4'h8, 32'h01);
        wr(4'h8, 32'h01);
        idle(1);
        chk("w1c_hw", {26'd0, HWInt}, 32'd0);

        // Sustained high latches once; W1C afterwards sticks.
        src = 6'h01;
        idle(20);
        chk("hold_hw", {26'd0, HWInt}, 32'h01);
        wr(4'h8, 32'h01);
        idle(5);
        chk("hold_once", {26'd0, HWInt}, 32'd0);
        src = 6'h00;
        idle(4);

        // Rising edge seen on the same edge as W1C: set wins.
        src = 6'h01;
        idle(1);
        src = 6'h00;
        idle(5);
        src = 6'h01;
        idle(2);
        wr(4'h8, 32'h01);
        rd_chk("setwins_pend", 4'h8, 32'h01);
        idle(1);
        chk("setwins_hw", {26'd0, HWInt}, 32'h01);
        src = 6'h00;
        idle(3);

        // Priority and mask: PEND=0x0A.
        wr(4'h4, 32'h0A);
        src = 6'h0A;
        idle(1);
        src = 6'h00;
        idle(4);
        wr(4'h0, 32'h08);
        idle(2);
        chk("pri_hw", {26'd0, HWInt}, 32'h08);
        rd_chk("pri_top3", 4'hC, 32'h8000_0003);
        wr(4'h0, 32'h0A);
        rd_chk("pri_top1", 4'hC, 32'h8000_0001);
        idle(1);
        chk("pri_hw2", {26'd0, HWInt}, 32'h0A);

        // Mode flip to level with src low clears the latched bit.
        wr(4'h4, 32'h08);
        rd_chk("flip_pend", 4'h8, 32'h08);

        // Async reset with every source active.
        wr(4'h4, 32'h00);
        wr(4'h0, 32'h3F);
        src = 6'h3F;
        idle(5);
        chk("all_hw", {26'd0, HWInt}, 32'h3F);
        async_reset();
        src = 6'h00;
        idle(2);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            src          = 6'($urandom);
            bus_if.addr  = 4'($urandom);
            bus_if.wdata = $urandom;
            bus_if.we    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                bus_if.we = 1'b0;
                async_reset();
            end else begin
                tick();
            end
        end
        bus_if.we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
